iso7816_3_t0_byte_logger: RTL and testbench

Timestamped record logger downstream of the ISO7816-3 T=0 analyzer. Captures every byte the analyzer reports (data, transmit direction, frame error) plus activation/deactivation events, packs each into a 32-bit record and buffers it in an internal FIFO. A host-side reader drains the FIFO over a valid/ready handshake. Overflow never stalls the analyzer: records are dropped, counted, and the next stored record is flagged.

---
 rtl/iso7816_3_t0_byte_logger.sv | 155 +++++++++++++++
 tb/tb_iso7816_3_t0_byte_logger.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iso7816_3_t0_byte_logger.sv
// Timestamped record logger behind the ISO7816-3 T=0 analyzer.
// Define LOGGER_TIMESTAMP_EN to build the ISO-clock delta counter.
module iso7816_3_t0_byte_logger #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  isoClkTick,
    input  logic                  isActivated,
    input  logic                  byteStrobe,
    input  logic [7:0]            byteData,
    input  logic                  cardTx,
    input  logic                  termTx,
    input  logic                  frameError,
    output logic                  recValid,
    input  logic                  recReady,
    output logic [31:0]           recData,
    output logic [ADDR_WIDTH:0]   level,
    output logic [7:0]            dropCnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [7:0]            drop_q, drop_d;
    logic                  act_q;
    logic                  mkPend_q, mkPend_d;
    logic                  mkAct_q, mkAct_d;
    logic                  lost_q, lost_d;

    logic        actEdge;
    logic        full;
    logic        push;
    logic        pop;
    logic        accept;
    logic        drop;
    logic [1:0]  recType;
    logic [15:0] delta;
    logic [31:0] rec;

    assign recValid = (level_q != '0);
    assign full     = (level_q == FULL);
    assign pop      = recValid & recReady;
    assign push     = byteStrobe | mkPend_q;
    assign accept   = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign actEdge  = isActivated ^ act_q;

`ifdef LOGGER_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;

    // The push cycle's own tick belongs to the record being written.
    always_comb begin
        delta = ts_q;
        if (isoClkTick && ts_q != 16'hFFFF) begin
            delta = ts_q + 16'd1;
        end
        ts_d = accept ? 16'd0 : delta;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    logic unusedTick;
    assign unusedTick = isoClkTick;
    assign delta      = 16'd0;
`endif

    always_comb begin
        recType = 2'b00;
        if (!byteStrobe) begin
            recType = mkAct_q ? 2'b01 : 2'b10;
        end
        rec = {delta, recType, 2'b00, 1'b0, lost_q, 2'b00, 8'h00};
        if (byteStrobe) begin
            rec[13:12] = {cardTx, termTx};
            rec[11]    = frameError;
            rec[7:0]   = byteData;
        end
    end

    always_comb begin
        mkAct_d  = actEdge ? isActivated : mkAct_q;
        mkPend_d = mkPend_q;
        if (actEdge) begin
            mkPend_d = 1'b1;
        end else if (mkPend_q && !byteStrobe) begin
            mkPend_d = 1'b0;
        end
        lost_d = lost_q;
        if (drop) begin
            lost_d = 1'b1;
        end else if (accept) begin
            lost_d = 1'b0;
        end
        drop_d = drop_q;
        if (drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        wptr_d  = accept ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            act_q    <= 1'b0;
            mkPend_q <= 1'b0;
            mkAct_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            act_q    <= isActivated;
            mkPend_q <= mkPend_d;
            mkAct_q  <= mkAct_d;
            lost_q   <= lost_d;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wptr_q] <= rec;
        end
    end

    assign recData = recValid ? mem_q[rptr_q] : 32'h0;
    assign level   = level_q;
    assign dropCnt = drop_q;

endmodule

// File: tb/tb_iso7816_3_t0_byte_logger.sv
// Scoreboard bench for iso7816_3_t0_byte_logger (ADDR_WIDTH=2).
// Expected deltas follow LOGGER_TIMESTAMP_EN as the RTL does.
module tb_iso7816_3_t0_byte_logger;

    logic        clk = 1'b0;
    logic        nReset;
    logic        isoClkTick;
    logic        isActivated;
    logic        byteStrobe;
    logic [7:0]  byteData;
    logic        cardTx;
    logic        termTx;
    logic        frameError;
    logic        recValid;
    logic        recReady;
    logic [31:0] recData;
    logic [2:0]  level;
    logic [7:0]  dropCnt;

    int nchk = 0;
    int nfail = 0;
    logic [31:0] q[$];

    typedef struct {
        logic [7:0]  data;
        logic        ct;
        logic        tt;
        logic        fe;
        int          ticks;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[6];

    iso7816_3_t0_byte_logger #(.ADDR_WIDTH(2)) dut (
        .clk(clk),
        .nReset(nReset),
        .isoClkTick(isoClkTick),
        .isActivated(isActivated),
        .byteStrobe(byteStrobe),
        .byteData(byteData),
        .cardTx(cardTx),
        .termTx(termTx),
        .frameError(frameError),
        .recValid(recValid),
        .recReady(recReady),
        .recData(recData),
        .level(level),
        .dropCnt(dropCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] adj(input logic [31:0] r);
        logic [31:0] v;
        v = r;
`ifndef LOGGER_TIMESTAMP_EN
        v[31:16] = 16'h0;
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        if (nReset && recValid && recReady) begin
            nchk++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL pop_unexpected got=%h expected=none", recData);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                if (recData !== e) begin
                    nfail++;
                    $display("FAIL record got=%h expected=%h", recData, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] d, input logic ct,
                          input logic tt, input logic fe, input logic tk);
        byteStrobe = 1'b1;
        byteData   = d;
        cardTx     = ct;
        termTx     = tt;
        frameError = fe;
        isoClkTick = tk;
        step();
        byteStrobe = 1'b0;
        byteData   = 8'h00;
        cardTx     = 1'b0;
        termTx     = 1'b0;
        frameError = 1'b0;
        isoClkTick = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        recReady = 1'b1;
        while ((q.size() != 0 || level !== 3'd0) && n < 100) begin
            step();
            n++;
        end
        nchk++;
        if (n >= 100) begin
            nfail++;
            $display("FAIL drain_timeout got=%0d expected=0 pending", q.size());
        end
    endtask

    initial begin
        tv[0] = '{8'h3B, 1'b1, 1'b0, 1'b0, 372, 32'h0174_203B};
        tv[1] = '{8'h95, 1'b1, 1'b0, 1'b0, 372, 32'h0174_2095};
        tv[2] = '{8'hA4, 1'b0, 1'b1, 1'b1, 372, 32'h0174_18A4};
        tv[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 0,   32'h0000_30FF};
        tv[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 5,   32'h0005_0000};
        tv[5] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1,   32'h0001_085A};

        nReset = 1'b0;
        isoClkTick = 1'b0;
        isActivated = 1'b0;
        byteStrobe = 1'b0;
        byteData = 8'h00;
        cardTx = 1'b0;
        termTx = 1'b0;
        frameError = 1'b0;
        recReady = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, recValid}, 32'd0);
        chk("rst_data", recData, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_drop", {24'd0, dropCnt}, 32'd0);
        nReset = 1'b1;
        step();

        // activation marker then table of byte records
        recReady = 1'b1;
        isActivated = 1'b1;
        step();
        q.push_back(32'h0000_4000);
        step();
        foreach (tv[i]) begin
            if (tv[i].ticks > 1) begin
                isoClkTick = 1'b1;
                repeat (tv[i].ticks - 1) step();
            end
            q.push_back(adj(tv[i].exp));
            strobe(tv[i].data, tv[i].ct, tv[i].tt, tv[i].fe,
                   tv[i].ticks != 0);
        end
        drain();

        // deactivation marker
        isActivated = 1'b0;
        step();
        q.push_back(32'h0000_8000);
        step();
        // byte and activation edge in the same cycle
        isActivated = 1'b1;
        q.push_back(32'h0000_0055);
        strobe(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        isoClkTick = 1'b1;
        q.push_back(adj(32'h0001_4000));
        step();
        isoClkTick = 1'b0;
        // edge then strobe in the following cycle: marker waits
        isActivated = 1'b0;
        step();
        q.push_back(32'h0000_0066);
        strobe(8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        q.push_back(32'h0000_8000);
        step();
        isActivated = 1'b1;
        step();
        q.push_back(32'h0000_4000);
        step();
        drain();

        // overflow: 6 strobes into a 4-deep FIFO
        recReady = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) q.push_back(32'(i));
            strobe(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("ovf_level", {29'd0, level}, 32'd4);
        chk("ovf_drop", {24'd0, dropCnt}, 32'd2);
        chk("ovf_hold", recData, 32'h0000_0001);
        drain();
        q.push_back(32'h0000_0410);
        strobe(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        q.push_back(32'h0000_0011);
        strobe(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        chk("lost_drop", {24'd0, dropCnt}, 32'd2);

        // full FIFO, simultaneous push and pop
        recReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q.push_back(32'h20 + 32'(i));
            strobe(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("full_level", {29'd0, level}, 32'd4);
        recReady = 1'b1;
        q.push_back(32'h0000_0024);
        strobe(8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        recReady = 1'b0;
        chk("pp_level", {29'd0, level}, 32'd4);
        chk("pp_drop", {24'd0, dropCnt}, 32'd2);
        chk("pp_head", recData, 32'h0000_0021);
        drain();

        // delta saturation
        isoClkTick = 1'b1;
        repeat (69999) step();
        q.push_back(adj(32'hFFFF_0077));
        strobe(8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // reset with records queued, isActivated held high
        recReady = 1'b0;
        strobe(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(8'h83, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", {29'd0, level}, 32'd3);
        nReset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, recValid}, 32'd0);
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_drop", {24'd0, dropCnt}, 32'd0);
        chk("mid_rst_data", recData, 32'd0);
        q.delete();
        step();
        nReset = 1'b1;
        step();
        q.push_back(32'h0000_4000);
        step();
        drain();
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
